// File: rtl/fb_bram_arbiter.sv
// Single-port frame-buffer BRAM arbiter: scan-out reads take priority over draw-engine accesses.
// Defining FB_ARB_STARVE_GUARD_EN adds a wait counter that forces a draw grant after STARVE_LIMIT blocked cycles.
module fb_bram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 32,
  parameter int WE_W         = 4,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req_valid,
  output logic              scan_req_ready,
  input  logic [ADDR_W-1:0] scan_req_addr,
  output logic              scan_rsp_valid,
  output logic [DATA_W-1:0] scan_rsp_data,
  input  logic              draw_req_valid,
  output logic              draw_req_ready,
  input  logic [ADDR_W-1:0] draw_req_addr,
  input  logic [WE_W-1:0]   draw_req_we,
  input  logic [DATA_W-1:0] draw_req_wdata,
  output logic              draw_rsp_valid,
  output logic [DATA_W-1:0] draw_rsp_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [WE_W-1:0]   bram_we,
  input  logic [DATA_W-1:0] bram_dout
);

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
    $error("fb_bram_arbiter: RD_LAT must be 1 or 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("fb_bram_arbiter: STARVE_LIMIT must be at least 1");
  end
  if (WE_W * 8 != DATA_W) begin : g_bad_we_w
    $error("fb_bram_arbiter: WE_W must equal DATA_W/8");
  end

  logic scan_grant;
  logic draw_grant;
  logic draw_is_rd;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             force_draw;

  // A saturated counter hands this one cycle to the draw engine.
  always_comb begin
    force_draw     = (wait_cnt_q == CNT_W'(STARVE_LIMIT));
    scan_req_ready = ~rst & ~force_draw;
    draw_req_ready = ~rst & (force_draw | ~scan_req_valid);
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!draw_req_valid || draw_grant) begin
      wait_cnt_d = '0;
    end else if (!force_draw) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  always_comb begin
    scan_req_ready = ~rst;
    draw_req_ready = ~rst & ~scan_req_valid;
  end
`endif

  always_comb begin
    scan_grant = scan_req_valid & scan_req_ready;
    draw_grant = draw_req_valid & draw_req_ready & ~scan_grant;
    draw_is_rd = (draw_req_we == '0);
  end

  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;
  logic [WE_W-1:0]   bram_we_q, bram_we_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    bram_we_d   = '0;
    if (scan_grant) begin
      bram_addr_d = scan_req_addr;
      bram_din_d  = '0;
    end else if (draw_grant) begin
      bram_addr_d = draw_req_addr;
      bram_din_d  = draw_req_wdata;
      bram_we_d   = draw_req_we;
    end
  end

  // Tracking pipeline: bit RD_LAT lines up with bram_dout for the access issued RD_LAT+1 edges earlier.
  logic [RD_LAT:0] trk_rd_q, trk_rd_d;
  logic [RD_LAT:0] trk_own_q, trk_own_d;
  logic            exit_rd;
  logic            exit_own;

  always_comb begin
    trk_rd_d  = {trk_rd_q[RD_LAT-1:0], scan_grant | (draw_grant & draw_is_rd)};
    trk_own_d = {trk_own_q[RD_LAT-1:0], draw_grant};
    exit_rd   = trk_rd_q[RD_LAT];
    exit_own  = trk_own_q[RD_LAT];
  end

  logic              scan_rsp_valid_q, scan_rsp_valid_d;
  logic              draw_rsp_valid_q, draw_rsp_valid_d;
  logic [DATA_W-1:0] scan_rsp_data_q, scan_rsp_data_d;
  logic [DATA_W-1:0] draw_rsp_data_q, draw_rsp_data_d;

  always_comb begin
    scan_rsp_valid_d = exit_rd & ~exit_own;
    draw_rsp_valid_d = exit_rd & exit_own;
    scan_rsp_data_d  = scan_rsp_valid_d ? bram_dout : scan_rsp_data_q;
    draw_rsp_data_d  = draw_rsp_valid_d ? bram_dout : draw_rsp_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_addr_q      <= '0;
      bram_din_q       <= '0;
      bram_we_q        <= '0;
      trk_rd_q         <= '0;
      trk_own_q        <= '0;
      scan_rsp_valid_q <= 1'b0;
      draw_rsp_valid_q <= 1'b0;
      scan_rsp_data_q  <= '0;
      draw_rsp_data_q  <= '0;
    end else begin
      bram_addr_q      <= bram_addr_d;
      bram_din_q       <= bram_din_d;
      bram_we_q        <= bram_we_d;
      trk_rd_q         <= trk_rd_d;
      trk_own_q        <= trk_own_d;
      scan_rsp_valid_q <= scan_rsp_valid_d;
      draw_rsp_valid_q <= draw_rsp_valid_d;
      scan_rsp_data_q  <= scan_rsp_data_d;
      draw_rsp_data_q  <= draw_rsp_data_d;
    end
  end

  assign bram_addr      = bram_addr_q;
  assign bram_din       = bram_din_q;
  assign bram_we        = bram_we_q;
  assign scan_rsp_valid = scan_rsp_valid_q;
  assign scan_rsp_data  = scan_rsp_data_q;
  assign draw_rsp_valid = draw_rsp_valid_q;
  assign draw_rsp_data  = draw_rsp_data_q;

endmodule
